pc_npc_sequencer: RTL and testbench

Registered PC/nPC pair for the SPARC datapath, replacing the combinational PC select with a sequencer that owns both program counters. It implements delayed-branch semantics (PC follows nPC), annulled delay slots, trap entry via TBR with a one-cycle trap state, and a parametrised reset vector. It sits between the branch/trap control logic and instruction fetch, and exports the saved PC/nPC pair used for the trap window registers.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_incrementer.sv | 13 +
 rtl/pc_npc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_npc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC/nPC sequencer: Sel modes, FSM states and a small alignment helper.
package pc_seq_pkg;

    localparam logic [1:0] SEL_SEQ   = 2'b00;
    localparam logic [1:0] SEL_XFER  = 2'b01;
    localparam logic [1:0] SEL_TRAP  = 2'b10;
    localparam logic [1:0] SEL_ANNUL = 2'b11;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_TRAP = 1'b1
    } seq_state_e;

    // A transfer target must be word aligned; only the two low address bits matter.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_incrementer.sv
// Modulo-2^WIDTH adder that steps an address by one instruction (INC bytes).
module pc_incrementer #(
    parameter int WIDTH = 32,
    parameter int INC   = 4
) (
    input  logic [WIDTH-1:0] addr_i,
    output logic [WIDTH-1:0] sum_o
);

    // Carry out of the top bit is dropped: wrap-around is legal.
    assign sum_o = addr_i + WIDTH'(INC);

endmodule

// File: rtl/pc_npc_sequencer.sv
// Registered SPARC PC/nPC sequencer with delayed transfers, annulled slots and a one-cycle trap state.
// Optional build macro ALIGN_CHECK_EN: rejects word-misaligned transfer targets and flags Misalign.
module pc_npc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               INC       = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic [1:0]       Sel,
    input  logic [WIDTH-1:0] Target,
    input  logic [WIDTH-1:0] TBR,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] nPC,
    output logic [WIDTH-1:0] Saved_PC,
    output logic [WIDTH-1:0] Saved_nPC,
    output logic             Trap_Ack,
    output logic             Squash,
    output logic             Misalign
);

    localparam logic [WIDTH-1:0] RESET_NPC = RESET_VEC + WIDTH'(INC);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] npc_q, npc_d;
    logic [WIDTH-1:0] saved_pc_q, saved_pc_d;
    logic [WIDTH-1:0] saved_npc_q, saved_npc_d;
    logic             squash_q, squash_d;

    logic [WIDTH-1:0] npc_inc;
    logic [WIDTH-1:0] tbr_inc;
    logic             target_bad;

    pc_incrementer #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_npc_inc (
        .addr_i (npc_q),
        .sum_o  (npc_inc)
    );

    pc_incrementer #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_tbr_inc (
        .addr_i (TBR),
        .sum_o  (tbr_inc)
    );

`ifdef ALIGN_CHECK_EN
    assign target_bad = is_misaligned(Target[1:0]);
`else
    assign target_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        saved_pc_d  = saved_pc_q;
        saved_npc_d = saved_npc_q;
        squash_d    = 1'b0;

        case (state_q)
            S_TRAP: begin
                // Trap vector is already in PC; step into the handler and ignore Sel/Stall.
                pc_d    = npc_q;
                npc_d   = npc_inc;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (Sel == SEL_TRAP) begin
                    saved_pc_d  = pc_q;
                    saved_npc_d = npc_q;
                    pc_d        = TBR;
                    npc_d       = tbr_inc;
                    state_d     = S_TRAP;
                end else if (!Stall) begin
                    pc_d     = npc_q;
                    npc_d    = (Sel == SEL_XFER && !target_bad) ? Target : npc_inc;
                    squash_d = (Sel == SEL_ANNUL);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_VEC;
            npc_q       <= RESET_NPC;
            saved_pc_q  <= '0;
            saved_npc_q <= '0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            saved_pc_q  <= saved_pc_d;
            saved_npc_q <= saved_npc_d;
            squash_q    <= squash_d;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = (state_q == S_RUN) && (Sel == SEL_XFER) && !Stall && target_bad;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign Misalign = misalign_q;
`else
    assign Misalign = 1'b0;
`endif

    assign PC        = pc_q;
    assign nPC       = npc_q;
    assign Saved_PC  = saved_pc_q;
    assign Saved_nPC = saved_npc_q;
    assign Trap_Ack  = (state_q == S_TRAP);
    assign Squash    = squash_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Scoreboard bench for pc_npc_sequencer: directed test-plan sequences followed by random traffic.
module tb_pc_npc_sequencer;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h100;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic [1:0]  Sel = 2'b00;
    logic [31:0] Target = '0;
    logic [31:0] TBR = '0;
    logic [31:0] PC, nPC, Saved_PC, Saved_nPC;
    logic        Trap_Ack, Squash, Misalign;

    pc_npc_sequencer #(
        .WIDTH     (W),
        .RESET_VEC (RV),
        .INC       (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall     (Stall),
        .Sel       (Sel),
        .Target    (Target),
        .TBR       (TBR),
        .PC        (PC),
        .nPC       (nPC),
        .Saved_PC  (Saved_PC),
        .Saved_nPC (Saved_nPC),
        .Trap_Ack  (Trap_Ack),
        .Squash    (Squash),
        .Misalign  (Misalign)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] spc;
        logic [31:0] snpc;
        logic        ack;
        logic        sq;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // Reference model: architectural view of the two program counters.
    logic [31:0] m_pc, m_npc, m_spc, m_snpc;
    bit          m_in_trap, m_sq, m_mis;

    task automatic step(input bit rst, input bit stall, input logic [1:0] sel,
                        input logic [31:0] tgt, input logic [31:0] tbr);
        exp_t e;
        bit   bad_tgt;
        @(negedge Clk);
        Reset  = rst;
        Stall  = stall;
        Sel    = sel;
        Target = tgt;
        TBR    = tbr;
        bad_tgt = ALIGN && (tgt % 4 != 0);
        if (rst) begin
            m_pc = RV; m_npc = RV + 4; m_spc = 0; m_snpc = 0;
            m_in_trap = 0; m_sq = 0; m_mis = 0;
        end else if (m_in_trap) begin
            m_pc = m_npc; m_npc = m_npc + 4;
            m_in_trap = 0; m_sq = 0; m_mis = 0;
        end else if (sel == 2'b10) begin
            m_spc = m_pc; m_snpc = m_npc;
            m_pc = tbr; m_npc = tbr + 4;
            m_in_trap = 1; m_sq = 0; m_mis = 0;
        end else if (stall) begin
            m_sq = 0; m_mis = 0;
        end else begin
            m_pc  = m_npc;
            m_npc = (sel == 2'b01 && !bad_tgt) ? tgt : m_npc + 4;
            m_sq  = (sel == 2'b11);
            m_mis = (sel == 2'b01) && bad_tgt;
        end
        e.pc = m_pc; e.npc = m_npc; e.spc = m_spc; e.snpc = m_snpc;
        e.ack = m_in_trap; e.sq = m_sq; e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every edge that follows an issued cycle is checked against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("[TB] txn %0d rst=%0b stall=%0b sel=%0d PC=%h nPC=%h sPC=%h snPC=%h ack=%0b sq=%0b mis=%0b",
                         n_txn, Reset, Stall, Sel, PC, nPC, Saved_PC, Saved_nPC, Trap_Ack, Squash, Misalign);
                check("PC",        PC,               e.pc);
                check("nPC",       nPC,              e.npc);
                check("Saved_PC",  Saved_PC,         e.spc);
                check("Saved_nPC", Saved_nPC,        e.snpc);
                check("Trap_Ack",  {31'b0, Trap_Ack}, {31'b0, e.ack});
                check("Squash",    {31'b0, Squash},   {31'b0, e.sq});
                check("Misalign",  {31'b0, Misalign}, {31'b0, e.mis});
            end
        end
    end

    initial begin
        logic [1:0]  sel;
        logic [31:0] tgt;
        // Reset and straight-line fetch
        step(1, 0, 2'b00, 0, 0);
        step(1, 0, 2'b00, 0, 0);
        repeat (3) step(0, 0, 2'b00, 0, 0);
        // Delayed branch from 0x200
        step(0, 0, 2'b01, 32'h200, 0);
        step(0, 0, 2'b00, 0, 0);
        step(0, 0, 2'b01, 32'h800, 0);
        step(0, 0, 2'b00, 0, 0);
        // Annul at 0x300
        step(0, 0, 2'b01, 32'h300, 0);
        step(0, 0, 2'b00, 0, 0);
        step(0, 0, 2'b11, 0, 0);
        step(0, 0, 2'b00, 0, 0);
        // Trap under stall at 0x400, Sel=01 presented during the trap state
        step(0, 0, 2'b01, 32'h400, 0);
        step(0, 0, 2'b00, 0, 0);
        step(0, 1, 2'b10, 0, 32'h1000);
        step(0, 0, 2'b01, 32'h2000, 0);
        step(0, 0, 2'b00, 0, 0);
        // Wrap, stall hold, reset in the trap state
        step(0, 0, 2'b01, 32'hFFFF_FFFC, 0);
        step(0, 0, 2'b00, 0, 0);
        repeat (3) step(0, 1, 2'b00, 32'h40, 0);
        step(0, 1, 2'b11, 0, 0);
        step(0, 0, 2'b10, 0, 32'h1000);
        step(1, 0, 2'b01, 32'h500, 0);
        step(0, 0, 2'b00, 0, 0);
        // Misaligned transfer target
        step(0, 0, 2'b01, 32'h802, 0);
        step(0, 0, 2'b00, 0, 0);
        step(0, 0, 2'b01, 32'h803, 0);
        step(0, 1, 2'b01, 32'h801, 0);
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0 && sel == 2'b10) sel = 2'b00;
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, sel, tgt, $urandom());
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge Clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
